// File: rtl/game_pkg.sv
// Shared state encoding, PS/2 set-2 key codes and key decode helper for game_session_ctrl.
// ST_PAUSED is only reachable when GAME_PAUSE_EN is defined.
package game_pkg;

   typedef enum logic [2:0] {
      ST_SEL_SPEED = 3'd0,
      ST_SEL_DIFF  = 3'd1,
      ST_READY     = 3'd2,
      ST_PLAYING   = 3'd3,
      ST_OVER      = 3'd4,
      ST_PAUSED    = 3'd5
   } state_t;

   localparam logic [7:0] KEY_1     = 8'h16;
   localparam logic [7:0] KEY_2     = 8'h1E;
   localparam logic [7:0] KEY_3     = 8'h26;
   localparam logic [7:0] KEY_SPACE = 8'h29;
   localparam logic [7:0] KEY_ESC   = 8'h76;
   localparam logic [7:0] KEY_P     = 8'h4D;
   localparam logic [7:0] KEY_BREAK = 8'hF0;
   localparam logic [7:0] KEY_EXT   = 8'hE0;

   // Maps the digit keys to 1..3; anything else returns 0 (not a digit).
   function automatic logic [1:0] digitValue(input logic [7:0] code);
      logic [1:0] value;
      value = 2'd0;
      case (code)
         KEY_1:   value = 2'd1;
         KEY_2:   value = 2'd2;
         KEY_3:   value = 2'd3;
         default: value = 2'd0;
      endcase
      return value;
   endfunction

endpackage

// File: rtl/ps2_make_filter.sv
// Registered PS/2 scan decoder: drops break (F0 xx) and extended (E0 xx, E0 F0 xx)
// sequences and emits a one-cycle o_keyValid with the make code.
module ps2_make_filter
   import game_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rstN,
   input  logic [7:0] i_data,
   input  logic       i_dataEn,
   output logic       o_keyValid,
   output logic [7:0] o_keyCode
);

   logic       r_brk;
   logic       r_ext;
   logic       r_keyValid;
   logic [7:0] r_keyCode;

   // The byte after F0 always ends the sequence, which also closes a pending E0 F0 xx.
   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_brk      <= 1'b0;
         r_ext      <= 1'b0;
         r_keyValid <= 1'b0;
         r_keyCode  <= 8'h00;
      end else begin
         r_keyValid <= 1'b0;
         if (i_dataEn) begin
            if (r_brk) begin
               r_brk <= 1'b0;
               r_ext <= 1'b0;
            end else if (i_data == KEY_BREAK) begin
               r_brk <= 1'b1;
            end else if (i_data == KEY_EXT) begin
               r_ext <= 1'b1;
            end else if (r_ext) begin
               r_ext <= 1'b0;
            end else begin
               r_keyValid <= 1'b1;
               r_keyCode  <= i_data;
            end
         end
      end
   end

   assign o_keyValid = r_keyValid;
   assign o_keyCode  = r_keyCode;

endmodule

// File: rtl/game_session_ctrl.sv
// Keyboard-driven game session sequencer: speed/difficulty selection, ready, play with
// one-second countdown, game over. Optional pause state enabled by `define GAME_PAUSE_EN.
module game_session_ctrl
   import game_pkg::*;
#(
   parameter int CLK_HZ       = 50_000_000,
   parameter int GAME_SECONDS = 60
)
(
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] ps2_data,
   input  logic       ps2_data_en,
   output logic [1:0] speed,
   output logic [1:0] difficulty,
   output logic [2:0] state,
   output logic       game_active,
   output logic [7:0] time_left,
   output logic       game_over,
   output logic [7:0] disp_code
);

   localparam int               PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
   localparam logic [7:0]       TIME_INIT = 8'(GAME_SECONDS);

   logic               w_keyValid;
   logic [7:0]         w_keyCode;
   logic               w_isEsc;
   logic [1:0]         w_digit;
   logic               w_showTime;

   state_t             r_state;
   logic [1:0]         r_speed;
   logic [1:0]         r_diff;
   logic [7:0]         r_timeLeft;
   logic [PRESC_W-1:0] r_presc;
   logic               r_gameOver;

   state_t             w_stateNext;
   logic [1:0]         w_speedNext;
   logic [1:0]         w_diffNext;
   logic [7:0]         w_timeNext;
   logic [PRESC_W-1:0] w_prescNext;
   logic               w_gameOverNext;

   ps2_make_filter u_filter (
      .i_clk      (CLOCK_50),
      .i_rstN     (resetn),
      .i_data     (ps2_data),
      .i_dataEn   (ps2_data_en),
      .o_keyValid (w_keyValid),
      .o_keyCode  (w_keyCode)
   );

   assign w_isEsc = w_keyValid && (w_keyCode == KEY_ESC);
   assign w_digit = digitValue(w_keyCode);

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_SEL_SPEED;
         r_speed    <= 2'd0;
         r_diff     <= 2'd0;
         r_timeLeft <= 8'd0;
         r_presc    <= '0;
         r_gameOver <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_speed    <= w_speedNext;
         r_diff     <= w_diffNext;
         r_timeLeft <= w_timeNext;
         r_presc    <= w_prescNext;
         r_gameOver <= w_gameOverNext;
      end
   end

   // Esc is checked first so it overrides a coinciding final tick and its game_over pulse.
   always_comb begin
      w_stateNext    = r_state;
      w_speedNext    = r_speed;
      w_diffNext     = r_diff;
      w_timeNext     = r_timeLeft;
      w_prescNext    = r_presc;
      w_gameOverNext = 1'b0;
      if (w_isEsc) begin
         w_stateNext = ST_SEL_SPEED;
         w_timeNext  = 8'd0;
      end else begin
         case (r_state)
            ST_SEL_SPEED: begin
               if (w_keyValid && (w_digit != 2'd0)) begin
                  w_speedNext = w_digit;
                  w_stateNext = ST_SEL_DIFF;
               end
            end
            ST_SEL_DIFF: begin
               if (w_keyValid && (w_digit != 2'd0)) begin
                  w_diffNext  = w_digit;
                  w_stateNext = ST_READY;
               end
            end
            ST_READY: begin
               if (w_keyValid && (w_keyCode == KEY_SPACE)) begin
                  w_stateNext = ST_PLAYING;
                  w_timeNext  = TIME_INIT;
                  w_prescNext = '0;
               end
            end
            ST_PLAYING: begin
`ifdef GAME_PAUSE_EN
               if (w_keyValid && (w_keyCode == KEY_P)) begin
                  w_stateNext = ST_PAUSED;
               end else
`endif
               if (r_presc == PRESC_MAX) begin
                  w_prescNext = '0;
                  if (r_timeLeft == 8'd1) begin
                     w_timeNext     = 8'd0;
                     w_stateNext    = ST_OVER;
                     w_gameOverNext = 1'b1;
                  end else begin
                     w_timeNext = r_timeLeft - 8'd1;
                  end
               end else begin
                  w_prescNext = r_presc + 1'b1;
               end
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSED: begin
               if (w_keyValid && (w_keyCode == KEY_P)) begin
                  w_stateNext = ST_PLAYING;
               end
            end
`endif
            ST_OVER: begin
               if (w_keyValid) begin
                  w_stateNext = ST_SEL_SPEED;
               end
            end
            default: begin
               w_stateNext = ST_SEL_SPEED;
            end
         endcase
      end
   end

   always_comb begin
      w_showTime = (r_state == ST_PLAYING) || (r_state == ST_OVER);
`ifdef GAME_PAUSE_EN
      if (r_state == ST_PAUSED) begin
         w_showTime = 1'b1;
      end
`endif
   end

   assign state       = r_state;
   assign speed       = r_speed;
   assign difficulty  = r_diff;
   assign time_left   = r_timeLeft;
   assign game_over   = r_gameOver;
   assign game_active = (r_state == ST_PLAYING);
   assign disp_code   = w_showTime ? r_timeLeft : {2'b00, r_speed, 2'b00, r_diff};

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl with CLK_HZ=10, GAME_SECONDS=3; pause checks
// are selected by GAME_PAUSE_EN.
module tb_game_session_ctrl;

   logic       CLOCK_50;
   logic       resetn;
   logic [7:0] ps2_data;
   logic       ps2_data_en;
   logic [1:0] speed;
   logic [1:0] difficulty;
   logic [2:0] state;
   logic       game_active;
   logic [7:0] time_left;
   logic       game_over;
   logic [7:0] disp_code;

   int testCount = 0;
   int failCount = 0;

   game_session_ctrl #(
      .CLK_HZ       (10),
      .GAME_SECONDS (3)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .ps2_data    (ps2_data),
      .ps2_data_en (ps2_data_en),
      .speed       (speed),
      .difficulty  (difficulty),
      .state       (state),
      .game_active (game_active),
      .time_left   (time_left),
      .game_over   (game_over),
      .disp_code   (disp_code)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // Called at a negedge: strobes one byte for a single cycle, returns at the next negedge.
   task automatic applyStimulus(input logic [7:0] b);
      ps2_data    = b;
      ps2_data_en = 1'b1;
      @(negedge CLOCK_50);
      ps2_data_en = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_state"}, 32'(state), 32'd0);
      checkOutput({tag, "_speed"}, 32'(speed), 32'd0);
      checkOutput({tag, "_diff"}, 32'(difficulty), 32'd0);
      checkOutput({tag, "_time"}, 32'(time_left), 32'd0);
      checkOutput({tag, "_active"}, 32'(game_active), 32'd0);
      checkOutput({tag, "_over"}, 32'(game_over), 32'd0);
      checkOutput({tag, "_disp"}, 32'(disp_code), 32'h00);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetn      = 1'b0;
      ps2_data    = 8'h00;
      ps2_data_en = 1'b0;
      #1;
      checkResetOutputs("reset");
      @(negedge CLOCK_50);
      resetn = 1'b1;

      // Happy path with break codes interleaved
      applyStimulus(8'h1E); waitCycles(1);
      checkOutput("hp_speed", 32'(speed), 32'd2);
      checkOutput("hp_state_diff", 32'(state), 32'd1);
      applyStimulus(8'hF0); applyStimulus(8'h1E); waitCycles(1);
      checkOutput("hp_break_hold", 32'(state), 32'd1);
      applyStimulus(8'h26); waitCycles(1);
      checkOutput("hp_diff", 32'(difficulty), 32'd3);
      checkOutput("hp_state_ready", 32'(state), 32'd2);
      checkOutput("hp_disp_sel", 32'(disp_code), 32'h23);
      applyStimulus(8'hF0); applyStimulus(8'h26);
      applyStimulus(8'h29);
      checkOutput("hp_latency", 32'(state), 32'd2);
      waitCycles(1);
      checkOutput("hp_playing", 32'(state), 32'd3);
      checkOutput("hp_time3", 32'(time_left), 32'd3);
      checkOutput("hp_active", 32'(game_active), 32'd1);
      checkOutput("hp_disp_time", 32'(disp_code), 32'h03);
      waitCycles(10);
      checkOutput("hp_time2", 32'(time_left), 32'd2);
      waitCycles(19);
      checkOutput("hp_time1", 32'(time_left), 32'd1);
      checkOutput("hp_still_play", 32'(state), 32'd3);
      checkOutput("hp_no_over_yet", 32'(game_over), 32'd0);
      waitCycles(1);
      checkOutput("hp_over_state", 32'(state), 32'd4);
      checkOutput("hp_over_pulse", 32'(game_over), 32'd1);
      checkOutput("hp_over_time", 32'(time_left), 32'd0);
      checkOutput("hp_over_active", 32'(game_active), 32'd0);
      waitCycles(1);
      checkOutput("hp_pulse_once", 32'(game_over), 32'd0);
      checkOutput("hp_over_hold", 32'(state), 32'd4);

      applyStimulus(8'h1C); waitCycles(1);
      checkOutput("over_any_key", 32'(state), 32'd0);
      checkOutput("over_keep_speed", 32'(speed), 32'd2);
      checkOutput("over_keep_diff", 32'(difficulty), 32'd3);

      // Break and extended filtering in SEL_SPEED
      applyStimulus(8'hF0); applyStimulus(8'h16); waitCycles(1);
      checkOutput("brk_state", 32'(state), 32'd0);
      checkOutput("brk_speed", 32'(speed), 32'd2);
      applyStimulus(8'hE0); applyStimulus(8'h16); waitCycles(1);
      checkOutput("ext_state", 32'(state), 32'd0);
      applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h16); waitCycles(1);
      checkOutput("extbrk_state", 32'(state), 32'd0);
      checkOutput("extbrk_speed", 32'(speed), 32'd2);
      applyStimulus(8'h16); waitCycles(1);
      checkOutput("post_filter_speed", 32'(speed), 32'd1);
      applyStimulus(8'h1E); waitCycles(1);
      checkOutput("sel2_state", 32'(state), 32'd2);
      checkOutput("sel2_disp", 32'(disp_code), 32'h12);

      // Esc at time_left=2
      applyStimulus(8'h29); waitCycles(1);
      waitCycles(10);
      checkOutput("esc_pre_time", 32'(time_left), 32'd2);
      applyStimulus(8'h76);
      checkOutput("esc_latency", 32'(state), 32'd3);
      waitCycles(1);
      checkOutput("esc_state", 32'(state), 32'd0);
      checkOutput("esc_time", 32'(time_left), 32'd0);
      checkOutput("esc_speed", 32'(speed), 32'd1);
      checkOutput("esc_diff", 32'(difficulty), 32'd2);

      // Esc decoded in the same cycle as the final tick
      applyStimulus(8'h16); waitCycles(1);
      applyStimulus(8'h1E); waitCycles(1);
      applyStimulus(8'h29); waitCycles(1);
      checkOutput("coin_playing", 32'(state), 32'd3);
      waitCycles(28);
      applyStimulus(8'h76);
      checkOutput("coin_pre_time", 32'(time_left), 32'd1);
      waitCycles(1);
      checkOutput("coin_state", 32'(state), 32'd0);
      checkOutput("coin_no_over", 32'(game_over), 32'd0);
      checkOutput("coin_time", 32'(time_left), 32'd0);
      waitCycles(1);
      checkOutput("coin_no_over_late", 32'(game_over), 32'd0);

`ifdef GAME_PAUSE_EN
      // Pause at time_left=2, hold 50 cycles, resume from held prescaler
      applyStimulus(8'h1E); waitCycles(1);
      applyStimulus(8'h26); waitCycles(1);
      applyStimulus(8'h29); waitCycles(1);
      waitCycles(10);
      applyStimulus(8'h4D); waitCycles(1);
      checkOutput("pause_state", 32'(state), 32'd5);
      checkOutput("pause_active", 32'(game_active), 32'd0);
      checkOutput("pause_disp", 32'(disp_code), 32'h02);
      waitCycles(50);
      checkOutput("pause_hold_time", 32'(time_left), 32'd2);
      checkOutput("pause_hold_state", 32'(state), 32'd5);
      applyStimulus(8'h4D); waitCycles(1);
      checkOutput("resume_state", 32'(state), 32'd3);
      waitCycles(18);
      checkOutput("resume_time1", 32'(time_left), 32'd1);
      checkOutput("resume_no_over", 32'(game_over), 32'd0);
      waitCycles(1);
      checkOutput("resume_over", 32'(game_over), 32'd1);
      checkOutput("resume_over_state", 32'(state), 32'd4);
      applyStimulus(8'h76); waitCycles(1);
`else
      // 'P' has no effect without the pause feature
      applyStimulus(8'h29); waitCycles(1);
      checkOutput("p_ignored_pre", 32'(state), 32'd0);
      applyStimulus(8'h16); waitCycles(1);
      applyStimulus(8'h1E); waitCycles(1);
      applyStimulus(8'h29); waitCycles(1);
      applyStimulus(8'h4D); waitCycles(1);
      checkOutput("p_ignored_state", 32'(state), 32'd3);
      checkOutput("p_ignored_active", 32'(game_active), 32'd1);
      applyStimulus(8'h76); waitCycles(1);
`endif

      // Async reset mid-game with a pending break prefix
      applyStimulus(8'h26); waitCycles(1);
      applyStimulus(8'h16); waitCycles(1);
      applyStimulus(8'h29); waitCycles(1);
      checkOutput("rst_pre_play", 32'(state), 32'd3);
      waitCycles(5);
      applyStimulus(8'hF0);
      #2;
      resetn = 1'b0;
      #1;
      checkResetOutputs("midrst");
      @(negedge CLOCK_50);
      resetn = 1'b1;
      applyStimulus(8'h16); waitCycles(1);
      checkOutput("post_rst_state", 32'(state), 32'd1);
      checkOutput("post_rst_speed", 32'(speed), 32'd1);

      $display("test done: total=%0d bad=%0d", testCount, failCount);
      $finish;
   end

endmodule
